// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receiver.
//   i2s_state_e                  : framing state (SYNC, LEFT, RIGHT)
//   WIDTH_DEFAULT                : default sample width per channel
//   SERIAL_TO_LEFT_RIGHT_DEFAULT : default sclk periods per ws period
package i2s_pkg;

    localparam int WIDTH_DEFAULT                = 8;
    localparam int SERIAL_TO_LEFT_RIGHT_DEFAULT = 64;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for one edge-detected signal plus N plain data bits.
//   mclk    : sampling clock
//   rst_n   : asynchronous active-low reset, clears every flop
//   edge_in : asynchronous signal whose rising edge is reported
//   data_in : asynchronous signals that are only synchronised
//   data_q  : synchronised data_in
//   rise    : high for one cycle when synchronised edge_in goes 0 -> 1
module sync_edge_detect #(
    parameter int N = 1
) (
    input  logic         mclk,
    input  logic         rst_n,
    input  logic         edge_in,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] data_q,
    output logic         rise
);

    // bit 0 carries edge_in, bits N:1 carry data_in, so all inputs see
    // identical synchroniser latency
    logic [N:0] s0;
    logic [N:0] s1;
    logic       edge_d;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            s0     <= '0;
            s1     <= '0;
            edge_d <= 1'b0;
        end else begin
            s0     <= {data_in, edge_in};
            s1     <= s0;
            edge_d <= s1[0];
        end
    end

    assign data_q = s1[N:1];
    assign rise   = s1[0] & ~edge_d;

endmodule

// File: rtl/i2s_receiver.sv
// I2S slave receiver, oversampled in the mclk domain.
//   mclk, rst_n          : clock, asynchronous active-low reset
//   sclk, ws, sd_rx      : I2S bus inputs (asynchronous to mclk)
//   rx_data_l, rx_data_r : captured stereo frame
//   rx_valid / rx_ready  : frame handshake, data held until accepted
//   overrun              : one-cycle pulse, completed frame dropped
//   sync_err             : one-cycle pulse, framing error, back to SYNC
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int WIDTH                = WIDTH_DEFAULT,
    parameter int SERIAL_TO_LEFT_RIGHT = SERIAL_TO_LEFT_RIGHT_DEFAULT
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             ws,
    input  logic             sd_rx,
    output logic [WIDTH-1:0] rx_data_l,
    output logic [WIDTH-1:0] rx_data_r,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overrun,
    output logic             sync_err
);

    localparam int BW   = $clog2(WIDTH + 1);
    localparam int HW   = $clog2(SERIAL_TO_LEFT_RIGHT) + 1;
    localparam int HALF = SERIAL_TO_LEFT_RIGHT / 2;

    logic [1:0]       sync_q;
    logic             ws_s;
    logic             sd_s;
    logic             cap;

    i2s_state_e       state;
    logic             ws_last;
    logic [BW-1:0]    bit_cnt;
    logic [HW-1:0]    half_cnt;
    logic [WIDTH-1:0] sh_l;
    logic [WIDTH-1:0] sh_r;

    logic             ws_tr;
    logic             bit_full;
    logic             half_ovf;
    logic             shift_en;
    logic             frame_done;
    logic             err;

    sync_edge_detect #(.N(2)) u_sync (
        .mclk    (mclk),
        .rst_n   (rst_n),
        .edge_in (sclk),
        .data_in ({sd_rx, ws}),
        .data_q  (sync_q),
        .rise    (cap)
    );

    assign ws_s = sync_q[0];
    assign sd_s = sync_q[1];

    // ws is compared against its value at the previous capture, so only
    // transitions seen at sclk rising edges count
    assign ws_tr      = cap & (ws_s != ws_last);
    assign bit_full   = (bit_cnt == BW'(WIDTH));
    // counter already at HALF: one more edge without ws change exceeds it
    assign half_ovf   = cap & ~ws_tr & (state != SYNC) & (half_cnt >= HW'(HALF));
    assign shift_en   = cap & ~ws_tr & ~half_ovf & (state != SYNC) & ~bit_full;
    assign frame_done = shift_en & (state == RIGHT) & (bit_cnt == BW'(WIDTH - 1));
    assign err        = (state != SYNC) & ((ws_tr & ~bit_full) | half_ovf);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SYNC;
            ws_last  <= 1'b0;
            bit_cnt  <= '0;
            half_cnt <= '0;
            sh_l     <= '0;
            sh_r     <= '0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= err;
            if (cap) ws_last <= ws_s;
            if (err) begin
                state    <= SYNC;
                bit_cnt  <= '0;
                half_cnt <= '0;
                sh_l     <= '0;
                sh_r     <= '0;
            end else if (ws_tr) begin
                // the bit carried on the ws-change edge is the one-bit delay
                // slot and is not shifted in
                bit_cnt  <= '0;
                half_cnt <= '0;
                case (state)
                    SYNC:    if (!ws_s) state <= LEFT;
                    LEFT:    state <= RIGHT;
                    RIGHT:   state <= LEFT;
                    default: state <= SYNC;
                endcase
            end else if (cap && state != SYNC) begin
                half_cnt <= half_cnt + HW'(1);
                if (shift_en) begin
                    bit_cnt <= bit_cnt + BW'(1);
                    if (state == LEFT) sh_l <= {sh_l[WIDTH-2:0], sd_s};
                    else               sh_r <= {sh_r[WIDTH-2:0], sd_s};
                end
            end
        end
    end

    // output holding register; a frame completing on an accepting cycle
    // replaces the accepted one without a bubble
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_l <= '0;
            rx_data_r <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data_l <= sh_l;
                    rx_data_r <= {sh_r[WIDTH-2:0], sd_s};
                    rx_valid  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: an I2S bus driver with random words
// and junk slots, a frame-level expectation queue, and a monitor that checks
// handshake data, hold stability, latency and error/overrun pulse counts.
module tb_i2s_receiver;

    localparam int WIDTH = 8;
    localparam int S2LR  = 64;
    localparam int HALF  = S2LR / 2;
    localparam int HP    = 4;          // mclk cycles per sclk half period

    logic             mclk  = 1'b0;
    logic             rst_n = 1'b0;
    logic             sclk  = 1'b0;
    logic             ws    = 1'b1;
    logic             sd_rx = 1'b0;
    logic             rx_ready = 1'b0;
    logic [WIDTH-1:0] rx_data_l;
    logic [WIDTH-1:0] rx_data_r;
    logic             rx_valid;
    logic             overrun;
    logic             sync_err;

    always #5 mclk = ~mclk;

    i2s_receiver #(.WIDTH(WIDTH), .SERIAL_TO_LEFT_RIGHT(S2LR)) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .ws        (ws),
        .sd_rx     (sd_rx),
        .rx_data_l (rx_data_l),
        .rx_data_r (rx_data_r),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .overrun   (overrun),
        .sync_err  (sync_err)
    );

    typedef struct {
        logic [WIDTH-1:0] l;
        logic [WIDTH-1:0] r;
    } frame_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    frame_t exp_q[$];
    int     exp_ovr = 0, exp_err = 0, n_ovr = 0, n_err = 0;
    int     t_last = 0, t_mark = 0, t_err = 0;
    bit     coincide = 1'b0;
    frame_t coin;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one sclk period: ws/sd change with sclk low, sclk rises halfway
    task automatic send_bit(input logic w, input logic d, input bit last, input bit mark);
        @(negedge mclk);
        sclk = 1'b0; ws = w; sd_rx = d;
        repeat (HP - 1) @(negedge mclk);
        sclk = 1'b1;
        if (last) t_last = cyc;
        if (mark) t_mark = cyc;
        for (int k = 1; k < HP; k++) begin
            @(negedge mclk);
            // land the accepting handshake on the edge that publishes the frame
            if (last && coincide && k == 2) rx_ready = 1'b1;
            if (last && coincide && k == 3) begin
                #2;
                chk("coin_valid", {31'd0, rx_valid}, 1);
                chk("coin_l", {24'd0, rx_data_l}, {24'd0, coin.l});
                chk("coin_r", {24'd0, rx_data_r}, {24'd0, coin.r});
                chk("coin_ovr", {31'd0, overrun}, 0);
            end
        end
    endtask

    // slot 0 carries the ws change, slots 1..nbits carry word MSB first
    task automatic send_half(input logic w, input logic [WIDTH-1:0] word, input int nbits,
                             input int nslots, input int last_slot, input int mark_slot);
        logic d;
        for (int s = 0; s < nslots; s++) begin
            if (s >= 1 && s <= nbits) d = word[WIDTH - s];
            else                      d = 1'($urandom());
            send_bit(w, d, s == last_slot, s == mark_slot);
        end
    endtask

    task automatic send_frame(input frame_t f, input bit push);
        if (push) exp_q.push_back(f);
        send_half(1'b0, f.l, WIDTH, HALF, -1, -1);
        send_half(1'b1, f.r, WIDTH, HALF, WIDTH, -1);
    endtask

    function automatic frame_t rnd_frame();
        frame_t f;
        f.l = WIDTH'($urandom());
        f.r = WIDTH'($urandom());
        return f;
    endfunction

    task automatic monitor();
        logic             pv = 1'b0, pacc = 1'b0;
        logic [WIDTH-1:0] pl = '0, pr = '0;
        frame_t           f;
        forever begin
            @(negedge mclk);
            #1;
            if (!rst_n) begin
                pv = 1'b0; pacc = 1'b0;
            end else begin
                if (sync_err) begin n_err++; t_err = cyc; end
                if (overrun) n_ovr++;
                if (rx_valid && !pv) chk("latency", cyc - t_last, 3);
                if (rx_valid && pv && !pacc) begin
                    chk("hold_l", {24'd0, rx_data_l}, {24'd0, pl});
                    chk("hold_r", {24'd0, rx_data_r}, {24'd0, pr});
                end
                if (rx_valid && rx_ready) begin
                    chk("frame_expected", {31'd0, exp_q.size() != 0}, 1);
                    if (exp_q.size() != 0) begin
                        f = exp_q.pop_front();
                        chk("data_l", {24'd0, rx_data_l}, {24'd0, f.l});
                        chk("data_r", {24'd0, rx_data_r}, {24'd0, f.r});
                    end
                end
                pv = rx_valid; pacc = rx_valid && rx_ready;
                pl = rx_data_l; pr = rx_data_r;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f1, fa, fb;
        fork monitor(); join_none

        // reset state
        repeat (3) @(negedge mclk);
        #2;
        chk("rst_valid", {31'd0, rx_valid}, 0);
        chk("rst_l", {24'd0, rx_data_l}, 0);
        chk("rst_r", {24'd0, rx_data_r}, 0);
        chk("rst_ovr", {31'd0, overrun}, 0);
        chk("rst_err", {31'd0, sync_err}, 0);
        @(negedge mclk);
        rst_n = 1'b1;
        rx_ready = 1'b1;

        // streaming with a ready consumer: leading right half, then frames
        send_half(1'b1, '0, 0, HALF, -1, -1);
        for (int i = 0; i < 5; i++) send_frame(rnd_frame(), 1'b1);
        f1.l = 8'hA5; f1.r = 8'h3C;
        send_frame(f1, 1'b1);
        chk("p1_ovr", n_ovr, exp_ovr);
        chk("p1_err", n_err, exp_err);

        // consumer stalled for 3 frames: first held, two dropped
        rx_ready = 1'b0;
        f1 = rnd_frame();
        send_frame(f1, 1'b1);
        send_frame(rnd_frame(), 1'b0); exp_ovr++;
        send_frame(rnd_frame(), 1'b0); exp_ovr++;
        chk("held_valid", {31'd0, rx_valid}, 1);
        chk("held_l", {24'd0, rx_data_l}, {24'd0, f1.l});
        chk("held_r", {24'd0, rx_data_r}, {24'd0, f1.r});
        chk("p2_ovr", n_ovr, exp_ovr);
        @(negedge mclk);
        rx_ready = 1'b1;
        @(negedge mclk);
        #2;
        chk("valid_fall", {31'd0, rx_valid}, 0);

        // completion coincides with an accepting handshake
        rx_ready = 1'b0;
        fa = rnd_frame();
        send_frame(fa, 1'b1);
        fb = rnd_frame();
        coin = fb;
        coincide = 1'b1;
        send_frame(fb, 1'b1);
        coincide = 1'b0;
        chk("p3_ovr", n_ovr, exp_ovr);

        // short left word (5 bits) before ws rises
        send_half(1'b0, WIDTH'($urandom()), 5, 6, -1, -1);
        send_half(1'b1, '0, 0, HALF, -1, 0);
        exp_err++;
        chk("short_err", n_err, exp_err);
        chk("short_err_lat", t_err - t_mark, 3);
        send_frame(rnd_frame(), 1'b1);
        send_frame(rnd_frame(), 1'b1);

        // ws held low for 40 sclk periods: error on 33rd edge after change
        send_half(1'b0, WIDTH'($urandom()), WIDTH, 40, -1, 33);
        exp_err++;
        chk("hold_err", n_err, exp_err);
        chk("hold_err_edge", t_err - t_mark, 3);
        send_half(1'b1, '0, 0, HALF, -1, -1);
        send_frame(rnd_frame(), 1'b1);
        send_frame(rnd_frame(), 1'b1);

        // reset mid right word with a frame held at the output
        rx_ready = 1'b0;
        send_frame(rnd_frame(), 1'b0);
        chk("pre_rst_valid", {31'd0, rx_valid}, 1);
        send_half(1'b0, WIDTH'($urandom()), WIDTH, HALF, -1, -1);
        send_half(1'b1, WIDTH'($urandom()), WIDTH, 5, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, rx_valid}, 0);
        chk("mid_rst_l", {24'd0, rx_data_l}, 0);
        chk("mid_rst_r", {24'd0, rx_data_r}, 0);
        chk("mid_rst_pulses", {30'd0, overrun, sync_err}, 0);
        repeat (3) @(negedge mclk);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        send_half(1'b1, '0, 0, HALF - 5, -1, -1);
        send_frame(rnd_frame(), 1'b1);
        send_frame(rnd_frame(), 1'b1);

        repeat (20) @(negedge mclk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        chk("overrun_total", n_ovr, exp_ovr);
        chk("sync_err_total", n_err, exp_err);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
